// File: rtl/flow_sequencer.sv
// flow_sequencer: single arbitrated sequencer for CALL / RET / INT / RTI.
// Injects fixed micro-instruction streams into the FD register, holds the PC
// incrementor while a stream runs, and issues PC redirects.
// Optional feature macro: FLOW_SEQ_INT_EN (interrupt entry sequence, pending
// flag and ack). When undefined, int_flag is ignored and ack is tied low.
// Raw-strobe gating of the PC incrementor during the decode cycle belongs to
// the enclosing pipeline top; every output here is a pure register.
module flow_sequencer #(
  parameter logic [15:0] NOP_INSTR      = 16'h0000,
  parameter logic [15:0] PUSH_PCH_INSTR = 16'h6080,
  parameter logic [15:0] PUSH_PCL_INSTR = 16'h6100,
  parameter logic [15:0] PUSH_CCR_INSTR = 16'h6180,
  parameter logic [15:0] POP_PCL_INSTR  = 16'h6200,
  parameter logic [15:0] POP_PCH_INSTR  = 16'h6280,
  parameter logic [15:0] POP_CCR_INSTR  = 16'h6300,
  parameter logic [31:0] INT_VECTOR     = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        call,
  input  logic        ret,
  input  logic        rti,
  input  logic [15:0] rdst_value,
  input  logic        int_flag,
  output logic        stall,
  output logic        inject,
  output logic [15:0] instr,
  output logic        pc_change,
  output logic [31:0] pc_value,
  output logic        ack
);

  typedef enum logic [3:0] {
    IDLE,
    CALL0, CALL1, CALL2,
    RET0,  RET1,  RET2,
    RTI0,  RTI1,  RTI2,  RTI3
`ifdef FLOW_SEQ_INT_EN
    , INT0, INT1, INT2, INT3
`endif
  } state_t;

  state_t      state;
  logic [15:0] rdst_latched;

`ifdef FLOW_SEQ_INT_EN
  logic int_pending;

  // Pending interrupt: any int_flag cycle sets it, entering INT0 clears it
  // (clear wins, so a request coinciding with entry collapses into that entry).
  always_ff @(posedge clk) begin
    if (reset) begin
      int_pending <= 1'b0;
    end else if (state == IDLE && !rti && !ret && !call && int_pending) begin
      int_pending <= 1'b0;
    end else if (int_flag) begin
      int_pending <= 1'b1;
    end
  end
`else
  logic unused_int_flag;
  assign unused_int_flag = int_flag;
  assign ack = 1'b0;
`endif

  // Sequencer: next state and the registered outputs for that state in one step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rdst_latched <= 16'h0000;
      stall        <= 1'b0;
      inject       <= 1'b0;
      instr        <= NOP_INSTR;
      pc_change    <= 1'b0;
      pc_value     <= 32'h0000_0000;
`ifdef FLOW_SEQ_INT_EN
      ack          <= 1'b0;
`endif
    end else begin
      stall     <= 1'b1;
      inject    <= 1'b1;
      instr     <= NOP_INSTR;
      pc_change <= 1'b0;
      pc_value  <= 32'h0000_0000;
`ifdef FLOW_SEQ_INT_EN
      ack       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rti) begin
            state <= RTI0;
            instr <= POP_CCR_INSTR;
          end else if (ret) begin
            state <= RET0;
            instr <= POP_PCL_INSTR;
          end else if (call) begin
            state        <= CALL0;
            instr        <= PUSH_PCH_INSTR;
            rdst_latched <= rdst_value;
`ifdef FLOW_SEQ_INT_EN
          end else if (int_pending) begin
            state <= INT0;
            instr <= PUSH_PCH_INSTR;
            ack   <= 1'b1;
`endif
          end else begin
            state  <= IDLE;
            stall  <= 1'b0;
            inject <= 1'b0;
          end
        end
        CALL0: begin
          state <= CALL1;
          instr <= PUSH_PCL_INSTR;
        end
        CALL1: begin
          state     <= CALL2;
          pc_change <= 1'b1;
          pc_value  <= {16'h0000, rdst_latched};
        end
        RET0: begin
          state <= RET1;
          instr <= POP_PCH_INSTR;
        end
        RET1: begin
          state <= RET2;
        end
        RTI0: begin
          state <= RTI1;
          instr <= POP_PCL_INSTR;
        end
        RTI1: begin
          state <= RTI2;
          instr <= POP_PCH_INSTR;
        end
        RTI2: begin
          state <= RTI3;
        end
`ifdef FLOW_SEQ_INT_EN
        INT0: begin
          state <= INT1;
          instr <= PUSH_PCL_INSTR;
        end
        INT1: begin
          state <= INT2;
          instr <= PUSH_CCR_INSTR;
        end
        INT2: begin
          state     <= INT3;
          pc_change <= 1'b1;
          pc_value  <= INT_VECTOR;
        end
`endif
        default: begin
          state  <= IDLE;
          stall  <= 1'b0;
          inject <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_sequencer.sv
// tb_flow_sequencer: directed test-plan checks with literal expectations, then
// randomized strobes checked every cycle against a queue-based stream model.
module tb_flow_sequencer;

`ifdef FLOW_SEQ_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        inject;
    logic [15:0] instr;
    logic        pc_change;
    logic [31:0] pc_value;
    logic        ack;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, call, ret, rti, int_flag;
  logic [15:0] rdst_value;
  logic        stall, inject, pc_change, ack;
  logic [15:0] instr;
  logic [31:0] pc_value;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  out_t exp_q[$];
  out_t m_cur;
  bit   m_pending = 1'b0;

  flow_sequencer dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .rti(rti),
    .rdst_value(rdst_value), .int_flag(int_flag),
    .stall(stall), .inject(inject), .instr(instr),
    .pc_change(pc_change), .pc_value(pc_value), .ack(ack)
  );

  always #5 clk = ~clk;

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t busy_out(input logic [15:0] w, input logic pcc,
                                    input logic [31:0] pcv, input logic a);
    out_t o;
    o.stall = 1'b1; o.inject = 1'b1; o.instr = w;
    o.pc_change = pcc; o.pc_value = pcv; o.ack = a;
    return o;
  endfunction

  // Reference model: each accepted event enqueues its whole output stream
  // followed by one mandatory IDLE cycle; the queue being empty means IDLE.
  always @(posedge clk) begin
    bit started_int;
    started_int = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_pending = 1'b0;
      m_cur = idle_out();
    end else if (exp_q.size() > 0) begin
      m_cur = exp_q.pop_front();
      if (INT_EN && int_flag) m_pending = 1'b1;
    end else begin
      if (rti) begin
        exp_q.push_back(busy_out(16'h6300, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h6200, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h6280, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h0000, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(idle_out());
      end else if (ret) begin
        exp_q.push_back(busy_out(16'h6200, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h6280, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h0000, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(idle_out());
      end else if (call) begin
        exp_q.push_back(busy_out(16'h6080, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h6100, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h0000, 1'b1, {16'h0000, rdst_value}, 1'b0));
        exp_q.push_back(idle_out());
      end else if (INT_EN && m_pending) begin
        started_int = 1'b1;
        exp_q.push_back(busy_out(16'h6080, 1'b0, 32'h0, 1'b1));
        exp_q.push_back(busy_out(16'h6100, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h6180, 1'b0, 32'h0, 1'b0));
        exp_q.push_back(busy_out(16'h0000, 1'b1, 32'h0000_0020, 1'b0));
        exp_q.push_back(idle_out());
      end
      if (started_int) m_pending = 1'b0;
      else if (INT_EN && int_flag) m_pending = 1'b1;
      m_cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_out();
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Every-cycle comparison of the whole output bundle against the model.
  always @(negedge clk) begin
    if (check_en)
      checkOutput("model", 64'({stall, inject, instr, pc_change, pc_value, ack}),
                  64'(m_cur));
  end

  task automatic applyStimulus(input logic r, input logic c, input logic rt,
                               input logic ri, input logic inf,
                               input logic [15:0] rd);
    reset = r; call = c; ret = rt; rti = ri; int_flag = inf; rdst_value = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_en = 1'b1;
    checkOutput("reset_stall", 64'(stall), 64'(0));
    checkOutput("reset_instr", 64'(instr), 64'(16'h0000));

    // CALL with target 0x0150
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0150);
    checkOutput("call0_instr", 64'(instr), 64'(16'h6080));
    checkOutput("call0_stall_inject", 64'({stall, inject}), 64'(2'b11));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    checkOutput("call1_instr", 64'(instr), 64'(16'h6100));
    idleCycle();
    checkOutput("call2_instr", 64'(instr), 64'(16'h0000));
    checkOutput("call2_pc_change", 64'(pc_change), 64'(1));
    checkOutput("call2_pc_value", 64'(pc_value), 64'(32'h0000_0150));
    idleCycle();
    checkOutput("call_done_stall", 64'(stall), 64'(0));

    // RET
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("ret0_instr", 64'(instr), 64'(16'h6200));
    idleCycle();
    checkOutput("ret1_instr", 64'(instr), 64'(16'h6280));
    idleCycle();
    checkOutput("ret2_instr", 64'(instr), 64'(16'h0000));
    checkOutput("ret2_pc_change", 64'(pc_change), 64'(0));
    idleCycle();

    // RTI and CALL collide: RTI wins, call dropped
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
    checkOutput("rti0_instr", 64'(instr), 64'(16'h6300));
    idleCycle();
    checkOutput("rti1_instr", 64'(instr), 64'(16'h6200));
    idleCycle();
    checkOutput("rti2_instr", 64'(instr), 64'(16'h6280));
    idleCycle();
    checkOutput("rti3_instr", 64'(instr), 64'(16'h0000));
    checkOutput("rti3_pc_change", 64'(pc_change), 64'(0));
    idleCycle();
    idleCycle();
    checkOutput("dropped_call_stall", 64'(stall), 64'(0));

`ifdef FLOW_SEQ_INT_EN
    // Interrupt pulse in IDLE: pending registers, then INT0 on next IDLE edge
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("int_pend_idle", 64'(stall), 64'(0));
    idleCycle();
    checkOutput("int0_ack", 64'(ack), 64'(1));
    checkOutput("int0_instr", 64'(instr), 64'(16'h6080));
    idleCycle();
    checkOutput("int1_instr", 64'(instr), 64'(16'h6100));
    checkOutput("int1_ack", 64'(ack), 64'(0));
    idleCycle();
    checkOutput("int2_instr", 64'(instr), 64'(16'h6180));
    idleCycle();
    checkOutput("int3_instr", 64'(instr), 64'(16'h0000));
    checkOutput("int3_pc", 64'({pc_change, pc_value}), 64'({1'b1, 32'h0000_0020}));
    idleCycle();

    // Interrupt during CALL1: call completes, one IDLE, then INT0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("call_int_pc_value", 64'(pc_value), 64'(32'h0000_0042));
    idleCycle();
    checkOutput("call_int_gap", 64'(stall), 64'(0));
    idleCycle();
    checkOutput("call_int_ack", 64'(ack), 64'(1));
    idleCycle();
    idleCycle();

    // Reset during INT2 kills the sequence and the pending flag
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("int_reset_idle", 64'({stall, inject, instr, pc_change, ack}), 64'(0));
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("no_ack_after_reset", 64'(ack), 64'(0));
    end
`else
    // Interrupts disabled: int_flag must be ignored entirely
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("int_ignored", 64'({stall, ack}), 64'(0));
    end
`endif

    // Randomized phase checked by the model process
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(9) == 0),
                    ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                    ($urandom_range(19) == 0), 16'($urandom));
    end
    idleCycle();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flow_sequencer.md
# flow_sequencer

Central multi-cycle flow controller for the five-stage pipeline. It replaces the separate call/ret/interrupt/rti FSMs with one arbitrated sequencer. It sits beside the fetch stage and watches the call/ret/rti strobes decoded in the decode stage plus the external interrupt line. For each event it injects a fixed micro-instruction stream into the FD pipeline register, holds the PC incrementor, and issues PC redirects.

## Interface
- `NOP_INSTR`, default 16'h0000: bubble word.
- `PUSH_PCH_INSTR`, default 16'h6080: push PC[31:16].
- `PUSH_PCL_INSTR`, default 16'h6100: push PC[15:0].
- `PUSH_CCR_INSTR`, default 16'h6180: push flags.
- `POP_PCL_INSTR`, default 16'h6200: pop PC[15:0].
- `POP_PCH_INSTR`, default 16'h6280: pop PC[31:16].
- `POP_CCR_INSTR`, default 16'h6300: pop flags.
- `INT_VECTOR`, default 32'h0000_0020: interrupt handler address.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `call` in 1: CALL decoded this cycle.
- `ret` in 1: RET decoded this cycle.
- `rti` in 1: RTI decoded this cycle.
- `rdst_value` in 16: CALL target, valid with `call`.
- `int_flag` in 1: external interrupt request, level-sampled.
- `stall` out 1: hold PC incrementor.
- `inject` out 1: FD input mux select; 1 selects `instr`.
- `instr` out 16: injected micro-instruction.
- `pc_change` out 1: load `pc_value` into PC this cycle.
- `pc_value` out 32: redirect target.
- `ack` out 1: interrupt accepted, one-cycle pulse.

## Operation
- States:
  - IDLE
  - CALL0–CALL2
  - RET0–RET2
  - INT0–INT3
  - RTI0–RTI3
- A 2-bit step counter plus a sequence-kind register is an acceptable encoding.
- IDLE outputs: stall=0, inject=0, instr=NOP_INSTR, pc_change=0, pc_value=0, ack=0.
- Every non-IDLE state drives stall=1 and inject=1.
- CALL:
  - CALL0 → PUSH_PCH_INSTR; CALL1 → PUSH_PCL_INSTR; CALL2 → NOP_INSTR.
  - In CALL2, pc_change=1 and pc_value={16'b0, rdst latched at acceptance}.
- RET:
  - RET0 → POP_PCL_INSTR; RET1 → POP_PCH_INSTR; RET2 → NOP_INSTR.
  - No pc_change; the PC is rewritten by the pops.
- INT:
  - INT0 → PUSH_PCH_INSTR, with ack=1.
  - INT1 → PUSH_PCL_INSTR; INT2 → PUSH_CCR_INSTR.
  - INT3 → NOP_INSTR, with pc_change=1 and pc_value=INT_VECTOR.
- RTI:
  - RTI0 → POP_CCR_INSTR; RTI1 → POP_PCL_INSTR; RTI2 → POP_PCH_INSTR; RTI3 → NOP_INSTR.
- The last state of each sequence always returns to IDLE.
- Arbitration happens only in IDLE. Priority is rti > ret > call > pending interrupt.
- Simultaneous strobes: the highest-priority one is taken and the rest are dropped. Such a collision is a decoder error and is not queued.
- Strobes arriving while not IDLE are ignored; those instructions are being flushed.
- Interrupt pending flag:
  - Set on any cycle with int_flag=1.
  - Cleared when INT0 is entered.
  - An interrupt that arrives during a sequence is serviced from the first IDLE cycle in which no decoded strobe is present.
  - Multiple requests before service collapse into one.
- Sequences are atomic. Nothing preempts a running sequence except reset.

## Timing
- All outputs are registered from state and are glitch-free.
- Acceptance latency is 1 cycle: a strobe sampled at edge N puts the first micro-word on `instr` during cycle N+1.
- The top level must also gate the PC incrementor with the raw call/ret/rti strobes during cycle N.
- Sequence lengths are CALL 3, RET 3, INT 4, RTI 4 cycles. Back-to-back sequences have at least one IDLE cycle between them.
- rdst_value is captured only at the CALL acceptance edge; later changes have no effect.
- Reset at any edge forces IDLE, all outputs to their IDLE values, and clears both the pending flag and the latched target. No partial sequence resumes.

## Configuration
- `FLOW_SEQ_INT_EN` defined: INT states, the pending flag and `ack` are implemented as above.
- `FLOW_SEQ_INT_EN` undefined:
  - INT states and the pending flag are not synthesized.
  - int_flag is ignored and ack is tied 0.
  - CALL, RET and RTI behaviour is unchanged.

## Test plan
- Reset, then call=1 with rdst_value=16'h0150 for one cycle → over the next 3 cycles instr = 16'h6080, 16'h6100, 16'h0000 with stall=inject=1. In the third cycle pc_change=1 and pc_value=32'h0000_0150. Next cycle returns to IDLE.
- ret=1 for one cycle → instr = 16'h6200, 16'h6280, 16'h0000; pc_change stays 0 throughout.
- int_flag pulsed 1 cycle in IDLE → ack=1 in the first cycle with instr 16'h6080, then 16'h6100, 16'h6180, 16'h0000. pc_change=1 with pc_value=32'h0000_0020 in the fourth cycle.
- int_flag pulsed during CALL1 → CALL finishes unchanged, one IDLE cycle follows, then INT0 with ack=1.
- rti=1 and call=1 in the same IDLE cycle → RTI stream 16'h6300, 16'h6200, 16'h6280, 16'h0000; the call is dropped and no pc_change occurs.
- reset asserted during INT2 → next cycle all outputs are at IDLE values, and no later ack occurs without a new int_flag.
